seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
- Multiplexed-display controller for N common-anode/cathode hex digits sharing one segment bus.
- Accepts a DIGITS*4-bit value over a valid/ready handshake and time-shares a single hex-to-segment decoder across digits.
- Drives one-hot digit enables with a programmable dwell and a ghost-suppression blanking gap.
- Sits between application logic (counters, UART debug bytes) and the board's display pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- DWELL_CYC, 1024, clk cycles each digit is lit (>=1).
- BLANK_CYC, 16, clk cycles all digits are off between slots (>=1).
- ACTIVE_LOW, 1, 1 = invert seg_out and dig_en at the pins (board drives low to light).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_data  in  DIGITS*4  hex nibbles; nibble 0 = rightmost digit.
- in_valid  in  1  in_data is offered.
- in_ready  out  1  controller can accept in_data this cycle.
- lz_en  in  1  leading-zero suppression enable (sampled every cycle).
- seg_out  out  7  segments {a,b,c,d,e,f,g} (bit6 = a), polarity per ACTIVE_LOW.
- dig_en  out  DIGITS  one-hot digit enable, polarity per ACTIVE_LOW.
- frame_start  out  1  one-cycle pulse when the digit-0 SHOW slot begins.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst), asserted at any time, all state returns to reset values immediately.
- Reset values:
  - state = BLANK, digit index = 0, cycle counter = 0.
  - display reg = 0, pending reg = 0, pending_full = 0.
  - seg_out and dig_en all off (all 1s when ACTIVE_LOW=1, all 0s otherwise).
  - frame_start = 0; in_ready = 1 (in_ready = ~pending_full, combinational).
- Handshake:
  - Transfer when in_valid && in_ready. in_data is copied to the pending reg; pending_full sets on the next edge.
  - in_valid while in_ready=0 has no effect; the source holds.
- Tear-free update: on the BLANK->SHOW edge for digit 0, if pending_full, then display <= pending and pending_full clears in the same edge.
  - If a transfer and this commit fall on the same edge, the commit uses the old pending value. The new value becomes pending and pending_full stays 1.
- FSM, 2 states, all outputs registered:
  - BLANK: dig_en off, seg_out off. Counter runs 0..BLANK_CYC-1, then -> SHOW with the index advanced (wraps DIGITS-1 -> 0). The first exit after reset enters SHOW with index 0.
  - SHOW: dig_en[idx] on, seg_out = decode(display nibble idx). Counter runs 0..DWELL_CYC-1, then -> BLANK.
- Timing:
  - Frame period = DIGITS*(DWELL_CYC+BLANK_CYC) cycles.
  - frame_start is high during the first SHOW cycle of digit 0.
  - Latency from an accepted transfer to the value lit is at most 1 frame + BLANK_CYC + 1 cycles.
- Leading-zero suppression (lz_en=1): in SHOW, seg_out is off for digit i when all nibbles i..DIGITS-1 are zero and i != 0. Digit 0 always shows. dig_en still asserts, so timing is unchanged.
- Decoder encoding (active-high, before polarity inversion):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - A=77, b=1F, C=4E, d=3D, E=4F, F=47.
- Exactly one dig_en bit is active in SHOW and none in BLANK; overlap never occurs.
- Counter width = clog2(max(DWELL_CYC, BLANK_CYC)); no overflow beyond terminal count.

Decomposition:
- Shared package seg_pkg:
  - the 16 segment-pattern constants and SEG_OFF = 7'h00;
  - state encoding constants ST_BLANK and ST_SHOW.
- One sub-module, hex_to_seg7: combinational 4-bit -> 7-bit active-high decoder using seg_pkg. The controller instantiates one copy and owns polarity inversion and the output registers.

Test Plan (DIGITS=2, DWELL_CYC=4, BLANK_CYC=1, ACTIVE_LOW=1 unless stated):
- Reset: assert rst mid-SHOW at an arbitrary cycle -> same cycle seg_out=7'h7F, dig_en=2'b11, in_ready=1. After release, the first SHOW begins 1 cycle later with dig_en=2'b10.
- Load 8'h3A with in_valid for 1 cycle -> in_ready low next cycle until the digit-0 commit.
  - Afterwards each frame: dig_en=2'b10 with seg_out=7'h08 for 4 cycles, 1 blank cycle, then dig_en=2'b01 with seg_out=7'h06 for 4 cycles.
  - Frame period is 10 cycles; frame_start pulses every 10 cycles.
- Back-pressure: offer 8'h11 then 8'h22 on consecutive cycles -> 8'h22 waits with in_ready=0. The 8'h11 frame displays first (seg 7'h4F on both digits), then 8'h22 (7'h12) from the next frame.
- Same-edge commit and transfer: pending=8'h55, new 8'h66 accepted exactly on the digit-0 commit edge -> 8'h55 is displayed, pending_full stays 1, and 8'h66 is displayed one frame later.
- LZS: lz_en=1, data 8'h05 -> digit1 slot seg_out=7'h7F with dig_en=2'b01 still asserted; digit0 shows 7'h24. Data 8'h00 -> digit0 shows 7'h01 (zero).
- Polarity: ACTIVE_LOW=0, data 8'h8F -> digit0 seg_out=7'h47, digit1 seg_out=7'h7F. dig_en is 2'b01 / 2'b10 while lit and 2'b00 when blank.

Source files
------------

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed seven-segment display slice.
//   - state_t          : scan FSM states (blank gap / digit lit)
//   - SEG_0 .. SEG_F   : active-high segment patterns {a,b,c,d,e,f,g}, bit6 = a
//   - SEG_OFF          : all segments dark (active-high sense)
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0   = 7'h7E;
    localparam logic [6:0] SEG_1   = 7'h30;
    localparam logic [6:0] SEG_2   = 7'h6D;
    localparam logic [6:0] SEG_3   = 7'h79;
    localparam logic [6:0] SEG_4   = 7'h33;
    localparam logic [6:0] SEG_5   = 7'h5B;
    localparam logic [6:0] SEG_6   = 7'h5F;
    localparam logic [6:0] SEG_7   = 7'h70;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h7B;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h1F;
    localparam logic [6:0] SEG_C   = 7'h4E;
    localparam logic [6:0] SEG_D   = 7'h3D;
    localparam logic [6:0] SEG_E   = 7'h4F;
    localparam logic [6:0] SEG_F   = 7'h47;
    localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational hex nibble to seven-segment decoder, active-high.
// Ports:
//   hex_in  : 4-bit value 0..F
//   seg_out : segments {a,b,c,d,e,f,g}, bit6 = a, 1 = segment lit
// Pin polarity is left to the instantiating controller.
// ---------------------------------------------------------------------------
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] hex_in,
    output logic [6:0] seg_out
);

    // Full 16-entry table, so no default path can ever be taken.
    always_comb begin
        seg_out = SEG_OFF;
        case (hex_in)
            4'h0: seg_out = SEG_0;
            4'h1: seg_out = SEG_1;
            4'h2: seg_out = SEG_2;
            4'h3: seg_out = SEG_3;
            4'h4: seg_out = SEG_4;
            4'h5: seg_out = SEG_5;
            4'h6: seg_out = SEG_6;
            4'h7: seg_out = SEG_7;
            4'h8: seg_out = SEG_8;
            4'h9: seg_out = SEG_9;
            4'hA: seg_out = SEG_A;
            4'hB: seg_out = SEG_B;
            4'hC: seg_out = SEG_C;
            4'hD: seg_out = SEG_D;
            4'hE: seg_out = SEG_E;
            4'hF: seg_out = SEG_F;
            default: seg_out = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Time-multiplexed controller for DIGITS hex digits sharing one segment bus.
// A new value is taken over a valid/ready handshake into a pending register
// and only copied into the displayed register when a frame restarts at
// digit 0, so a frame never mixes old and new digits.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   in_data      : DIGITS hex nibbles, nibble 0 = rightmost digit
//   in_valid     : in_data offered
//   in_ready     : pending register empty, an offer is taken this cycle
//   lz_en        : blank leading zeros (never digit 0)
//   seg_out      : registered segments {a..g}, polarity per ACTIVE_LOW
//   dig_en       : registered one-hot digit enable, polarity per ACTIVE_LOW
//   frame_start  : high during the first lit cycle of digit 0
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DWELL_CYC  = 1024,
    parameter int BLANK_CYC  = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*4-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  lz_en,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_start
);

    localparam int DATA_W  = DIGITS * 4;
    localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_IDLE   = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] DIG_IDLE   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   display_q, display_d;
    logic [DATA_W-1:0]   pending_q, pending_d;
    logic                pending_full_q, pending_full_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                frame_q, frame_d;

    logic                accept;
    logic                commit;
    logic [3:0]          cur_nibble;
    logic                upper_zero;
    logic                lz_blank;
    logic [6:0]          dec_seg;
    logic [6:0]          seg_act;
    logic [DIGITS-1:0]   dig_act;

    assign in_ready    = ~pending_full_q;
    assign seg_out     = seg_q;
    assign dig_en      = dig_q;
    assign frame_start = frame_q;

    // Scan sequencing. The digit index is stepped as a lit slot ends, so the
    // blank gap already carries the index of the digit it precedes and the
    // first gap after reset leads into digit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        commit  = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    commit  = (idx_q == '0) && pending_full_q;
                end
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake and tear-free commit. The commit always takes the value that
    // was pending before this edge; a same-edge transfer refills pending.
    always_comb begin
        accept         = in_valid && in_ready;
        display_d      = commit ? pending_q : display_q;
        pending_d      = accept ? in_data : pending_q;
        pending_full_d = accept || (pending_full_q && !commit);
    end

    // Pick the nibble for the digit lit after this edge, and whether it and
    // every more significant nibble are zero (leading-zero blanking).
    always_comb begin
        cur_nibble = '0;
        upper_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                cur_nibble = display_d[4*i +: 4];
                upper_zero = ((display_d >> (4*i)) == '0);
            end
        end
        lz_blank = lz_en && (idx_d != '0) && upper_zero;
    end

    hex_to_seg7 u_dec (
        .hex_in  (cur_nibble),
        .seg_out (dec_seg)
    );

    // Output registers are loaded from the next state so that pins change on
    // the same edge as the FSM, with pin polarity applied last.
    always_comb begin
        seg_act = SEG_OFF;
        dig_act = '0;
        if (state_d == ST_SHOW) begin
            dig_act = DIGITS'(1) << idx_d;
            if (!lz_blank) begin
                seg_act = dec_seg;
            end
        end
        seg_d   = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
        dig_d   = (ACTIVE_LOW != 0) ? ~dig_act : dig_act;
        frame_d = (state_q == ST_BLANK) && (state_d == ST_SHOW) && (idx_d == '0);
    end

    // All state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_BLANK;
            cnt_q          <= '0;
            idx_q          <= '0;
            display_q      <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            seg_q          <= SEG_IDLE;
            dig_q          <= DIG_IDLE;
            frame_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            display_q      <= display_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            seg_q          <= seg_d;
            dig_q          <= dig_d;
            frame_q        <= frame_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
// Two controllers (active-low and active-high pins, DIGITS=2, DWELL=4,
// BLANK=1) share one stimulus. A timeline model derives every output from the
// number of clock edges since reset plus the displayed/pending words.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

    localparam int DIGITS = 2;
    localparam int DWELL  = 4;
    localparam int BLANK  = 1;
    localparam int SLOT   = DWELL + BLANK;
    localparam int FRAME  = DIGITS * SLOT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              lz_en = 1'b0;

    logic              in_ready, in_ready_h;
    logic [6:0]        seg_out, seg_out_h;
    logic [1:0]        dig_en, dig_en_h;
    logic              frame_start, frame_start_h;

    int checks = 0;
    int errors = 0;

    // Timeline model state.
    longint     m_k    = 0;
    logic [7:0] m_disp = 8'h00;
    logic [7:0] m_pend = 8'h00;
    bit         m_full = 1'b0;
    bit         m_lz   = 1'b0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .DIGITS(DIGITS), .DWELL_CYC(DWELL), .BLANK_CYC(BLANK), .ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .lz_en(lz_en), .seg_out(seg_out),
        .dig_en(dig_en), .frame_start(frame_start)
    );

    seven_seg_scan_ctrl #(
        .DIGITS(DIGITS), .DWELL_CYC(DWELL), .BLANK_CYC(BLANK), .ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_h), .lz_en(lz_en), .seg_out(seg_out_h),
        .dig_en(dig_en_h), .frame_start(frame_start_h)
    );

    function automatic logic [6:0] hexSeg(input logic [3:0] h);
        logic [6:0] tab [16];
        tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return tab[h];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model advance on every edge: inputs are stable here because the
    // stimulus only moves them after an edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k    = 0;
            m_disp = 8'h00;
            m_pend = 8'h00;
            m_full = 1'b0;
            m_lz   = 1'b0;
        end else begin
            bit acc;
            bit com;
            acc = in_valid && !m_full;
            m_k = m_k + 1;
            com = (((m_k - 1) % FRAME) == 0) && m_full;
            if (com) m_disp = m_pend;
            if (acc) m_pend = in_data;
            m_full = (m_full && !com) || acc;
            m_lz   = lz_en;
        end
    end

    // Expected active-high outputs for the current point on the timeline.
    task automatic modelOutputs(output logic [6:0] es, output logic [1:0] ed, output logic ef);
        int p, d, w;
        logic [7:0] upper;
        es = 7'h00;
        ed = 2'b00;
        ef = 1'b0;
        if (m_k > 0) begin
            p = int'((m_k - 1) % FRAME);
            d = p / SLOT;
            w = p % SLOT;
            if (w < DWELL) begin
                ed    = 2'(1 << d);
                upper = m_disp >> (4 * d);
                if (!(m_lz && d != 0 && upper == 8'h00))
                    es = hexSeg(upper[3:0]);
                ef = (d == 0) && (w == 0);
            end
        end
    endtask

    // Every-cycle comparison of both controllers against the model.
    always @(negedge clk) begin
        logic [6:0] es;
        logic [1:0] ed;
        logic       ef;
        logic [6:0] es_n;
        logic [1:0] ed_n;
        modelOutputs(es, ed, ef);
        es_n = ~es;
        ed_n = ~ed;
        checkOutput("lo.seg_out", 32'(seg_out), 32'(es_n));
        checkOutput("lo.dig_en", 32'(dig_en), 32'(ed_n));
        checkOutput("lo.frame_start", 32'(frame_start), 32'(ef));
        checkOutput("lo.in_ready", 32'(in_ready), 32'(!m_full));
        checkOutput("hi.seg_out", 32'(seg_out_h), 32'(es));
        checkOutput("hi.dig_en", 32'(dig_en_h), 32'(ed));
        checkOutput("hi.frame_start", 32'(frame_start_h), 32'(ef));
        checkOutput("hi.in_ready", 32'(in_ready_h), 32'(!m_full));
    end

    task automatic skipCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the first falling edge where digit 0 has just been lit.
    task automatic waitFrameStart();
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        checkOutput("frame_start_timeout", 32'(0), 32'(1));
    endtask

    // Offer a word and hold it until accepted; returns on the falling edge
    // after the accepting edge. 'waited' tells whether it saw back-pressure.
    task automatic sendWord(input logic [7:0] w, output bit waited);
        bit done;
        waited = 1'b0;
        done   = 1'b0;
        @(negedge clk);
        #1;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1'b1;
            end else begin
                waited = 1'b1;
                @(negedge clk);
                #1;
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            checkOutput("send_timeout", 32'(0), 32'(1));
        end
        @(negedge clk);
    endtask

    // Random traffic with one asynchronous reset dropped in mid-cycle.
    task automatic applyStimulus(input int cycles, input int reset_at);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            #1;
            in_valid = ($urandom_range(0, 99) < 40);
            in_data  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
            if (c == reset_at) begin
                #1;
                rst = 1'b1;
                @(negedge clk);
                #1;
                rst = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        bit waited;

        // Reset held across edges, then the first lit slot.
        skipCycles(3);
        checkOutput("reset_seg", 32'(seg_out), 32'(7'h7F));
        checkOutput("reset_dig", 32'(dig_en), 32'(2'b11));
        checkOutput("reset_ready", 32'(in_ready), 32'(1));
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("first_show_dig", 32'(dig_en), 32'(2'b10));
        checkOutput("first_show_seg", 32'(seg_out), 32'(7'h01));
        checkOutput("first_show_fs", 32'(frame_start), 32'(1));

        // Asynchronous reset in the middle of a lit slot.
        skipCycles(2);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_seg", 32'(seg_out), 32'(7'h7F));
        checkOutput("midreset_dig", 32'(dig_en), 32'(2'b11));
        checkOutput("midreset_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("after_reset_dig", 32'(dig_en), 32'(2'b10));

        // Load 3A: ready drops, then A on digit 0 and 3 on digit 1.
        sendWord(8'h3A, waited);
        checkOutput("3A_ready_low", 32'(in_ready), 32'(0));
        waitFrameStart();
        checkOutput("3A_ready_back", 32'(in_ready), 32'(1));
        checkOutput("3A_d0_dig", 32'(dig_en), 32'(2'b10));
        checkOutput("3A_d0_seg", 32'(seg_out), 32'(7'h08));
        skipCycles(SLOT);
        checkOutput("3A_d1_dig", 32'(dig_en), 32'(2'b01));
        checkOutput("3A_d1_seg", 32'(seg_out), 32'(7'h06));
        skipCycles(SLOT);
        checkOutput("3A_period", 32'(frame_start), 32'(1));

        // Back-pressure: 22 waits behind 11.
        sendWord(8'h11, waited);
        sendWord(8'h22, waited);
        checkOutput("22_backpressured", 32'(waited), 32'(1));
        checkOutput("11_frame_seg", 32'(seg_out), 32'(7'h4F));
        checkOutput("11_frame_dig", 32'(dig_en), 32'(2'b10));
        waitFrameStart();
        checkOutput("22_frame_seg", 32'(seg_out), 32'(7'h12));
        skipCycles(SLOT);
        checkOutput("22_frame_d1_seg", 32'(seg_out), 32'(7'h12));

        // Leading-zero suppression.
        lz_en = 1'b1;
        sendWord(8'h05, waited);
        waitFrameStart();
        checkOutput("lz05_d0_seg", 32'(seg_out), 32'(7'h24));
        skipCycles(SLOT);
        checkOutput("lz05_d1_dig", 32'(dig_en), 32'(2'b01));
        checkOutput("lz05_d1_seg", 32'(seg_out), 32'(7'h7F));
        sendWord(8'h00, waited);
        waitFrameStart();
        checkOutput("lz00_d0_seg", 32'(seg_out), 32'(7'h01));
        skipCycles(SLOT);
        checkOutput("lz00_d1_seg", 32'(seg_out), 32'(7'h7F));
        lz_en = 1'b0;

        // Active-high pins.
        sendWord(8'h8F, waited);
        waitFrameStart();
        checkOutput("hi_d0_seg", 32'(seg_out_h), 32'(7'h47));
        checkOutput("hi_d0_dig", 32'(dig_en_h), 32'(2'b01));
        skipCycles(DWELL);
        checkOutput("hi_blank_dig", 32'(dig_en_h), 32'(2'b00));
        checkOutput("hi_blank_seg", 32'(seg_out_h), 32'(7'h00));
        skipCycles(BLANK);
        checkOutput("hi_d1_seg", 32'(seg_out_h), 32'(7'h7F));
        checkOutput("hi_d1_dig", 32'(dig_en_h), 32'(2'b10));

        // Randomized traffic against the model.
        applyStimulus(400, int'($urandom_range(100, 300)));
        skipCycles(3 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
